// File: rtl/uart_boot_ctrl.sv
// rtl/uart_boot_ctrl.sv - UART boot loader: frames an image from RX FIFO into imem, acks on TX FIFO
module uart_boot_ctrl #(
    parameter int unsigned IMEM_WORDS  = 256,
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_req_i,
    input  logic        rx_fifo_empty_i,
    input  logic [7:0]  rx_fifo_data_i,
    output logic        rx_fifo_rd_o,
    input  logic        tx_fifo_full_i,
    output logic        tx_fifo_wr_o,
    output logic [7:0]  tx_fifo_data_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        core_hold_o,
    output logic        boot_done_o,
    output logic        boot_err_o
);

    localparam int WIDX_W = $clog2(IMEM_WORDS) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_SYNC, S_CNT0, S_CNT1, S_DATA, S_CSUM, S_ACK, S_NAK, S_DONE, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [23:0]         wdata_q, wdata_d;
    logic [7:0]          csum_q, csum_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                imem_we_q, imem_we_d;
    logic [31:0]         imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                boot_err_q, boot_err_d;

    logic        receiving;
    logic        timed_state;
    logic        pop;
    logic        timeout;
    logic [15:0] n_val;

    // Nothing is popped while reset is asserted, even though the state reads SYNC.
    assign receiving   = (state_q inside {S_SYNC, S_CNT0, S_CNT1, S_DATA, S_CSUM, S_ERR});
    assign timed_state = (state_q inside {S_CNT0, S_CNT1, S_DATA, S_CSUM});
    assign pop         = rst_ni && receiving && !rx_fifo_empty_i;
    assign timeout     = timed_state && !pop && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
    assign n_val       = {rx_fifo_data_i, cnt_lo_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_SYNC;
            cnt_lo_q     <= '0;
            cnt_q        <= '0;
            byte_idx_q   <= '0;
            word_idx_q   <= '0;
            wdata_q      <= '0;
            csum_q       <= '0;
            idle_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            boot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            cnt_q        <= cnt_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            wdata_q      <= wdata_d;
            csum_q       <= csum_d;
            idle_q       <= idle_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            boot_err_q   <= boot_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        cnt_d        = cnt_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        wdata_d      = wdata_q;
        csum_d       = csum_q;
        idle_d       = '0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        boot_err_d   = boot_err_q;

        if (timed_state) begin
            idle_d = pop ? '0 : idle_q + 1'b1;
        end

        case (state_q)
            S_SYNC: begin
                cnt_lo_d   = '0;
                cnt_d      = '0;
                byte_idx_d = '0;
                word_idx_d = '0;
                wdata_d    = '0;
                csum_d     = '0;
                if (pop && rx_fifo_data_i == MAGIC) begin
                    state_d    = S_CNT0;
                    boot_err_d = 1'b0;
                end
            end
            S_CNT0: begin
                if (pop) begin
                    cnt_lo_d = rx_fifo_data_i;
                    state_d  = S_CNT1;
                end
            end
            S_CNT1: begin
                if (pop) begin
                    cnt_d = n_val;
                    if (n_val == 16'd0 || n_val > 16'(IMEM_WORDS)) begin
                        state_d = S_NAK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pop) begin
                    csum_d     = csum_q ^ rx_fifo_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: wdata_d[7:0]   = rx_fifo_data_i;
                        2'd1: wdata_d[15:8]  = rx_fifo_data_i;
                        2'd2: wdata_d[23:16] = rx_fifo_data_i;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = 32'({word_idx_q, 2'b00});
                            imem_wdata_d = {rx_fifo_data_i, wdata_q};
                            word_idx_d   = word_idx_q + 1'b1;
                            if (16'(word_idx_q) == cnt_q - 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (pop) begin
                    state_d = (rx_fifo_data_i == csum_q) ? S_ACK : S_NAK;
                end
            end
            S_ACK: begin
                if (!tx_fifo_full_i) begin
                    state_d = S_DONE;
                end
            end
            S_NAK: begin
                if (!tx_fifo_full_i) begin
                    state_d    = S_ERR;
                    boot_err_d = 1'b1;
                end
            end
            S_DONE: begin
                if (boot_req_i) begin
                    state_d = S_SYNC;
                end
            end
            S_ERR: begin
                if (boot_req_i || (pop && rx_fifo_data_i == MAGIC)) begin
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (timeout) begin
            state_d = S_NAK;
        end
    end

    assign rx_fifo_rd_o   = pop;
    assign tx_fifo_wr_o   = (state_q == S_ACK || state_q == S_NAK) && !tx_fifo_full_i;
    assign tx_fifo_data_o = (state_q == S_ACK) ? ACK_BYTE :
                            (state_q == S_NAK) ? NAK_BYTE : 8'h00;
    assign imem_we_o      = imem_we_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_wdata_o   = imem_wdata_q;
    assign core_hold_o    = (state_q != S_DONE);
    assign boot_done_o    = (state_q == S_DONE);
    assign boot_err_o     = boot_err_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// tb/tb_uart_boot_ctrl.sv - scoreboard bench for uart_boot_ctrl
module tb_uart_boot_ctrl;

    localparam int TMO = 64;
    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_req = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        rx_rd;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        boot_done;
    logic        boot_err;

    logic [7:0]  rxq[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          n_checks = 0;
    int          n_fail = 0;

    uart_boot_ctrl #(.IMEM_WORDS(256), .MAGIC(8'hA5), .TIMEOUT_CYC(TMO),
                     .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_req_i(boot_req),
        .rx_fifo_empty_i(rx_empty), .rx_fifo_data_i(rx_data), .rx_fifo_rd_o(rx_rd),
        .tx_fifo_full_i(tx_full), .tx_fifo_wr_o(tx_wr), .tx_fifo_data_o(tx_data),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .core_hold_o(core_hold), .boot_done_o(boot_done), .boot_err_o(boot_err)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic tick();
        logic        do_pop;
        logic [63:0] e;
        logic [7:0]  t;
        @(negedge clk);
        refresh();
        #1;
        if (imem_we) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL imem_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_wr.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (tx_wr) begin
            n_checks++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL tx_write: got %h, required no write", tx_data);
            end else begin
                t = exp_tx.pop_front();
                if (tx_data !== t) begin
                    n_fail++;
                    $display("FAIL tx_write: got %h, required %h", tx_data, t);
                end
            end
        end
        do_pop = rx_rd;
        @(posedge clk);
        if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
        #1;
        refresh();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) rxq.push_back(w[8*b +: 8]);
    endtask

    // Case-1 payload; a nonzero flip corrupts the checksum byte.
    task automatic send_frame(input logic [7:0] flip);
        logic [7:0] cs;
        cs = W0[7:0] ^ W0[15:8] ^ W0[23:16] ^ W0[31:24] ^
             W1[7:0] ^ W1[15:8] ^ W1[23:16] ^ W1[31:24];
        rxq.push_back(8'hA5); rxq.push_back(8'h02); rxq.push_back(8'h00);
        push_word(W0);
        push_word(W1);
        rxq.push_back(cs ^ flip);
        exp_wr.push_back({32'h0, W0});
        exp_wr.push_back({32'h4, W1});
        exp_tx.push_back((flip == 8'h00) ? 8'h06 : 8'h15);
    endtask

    task automatic wait_status(input string name, input logic done, input logic err, input int budget);
        int n;
        n = 0;
        while (n < budget && !(boot_done === done && boot_err === err && rxq.size() == 0 &&
                               exp_wr.size() == 0 && exp_tx.size() == 0)) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: wr_left=%0d tx_left=%0d rx_left=%0d, required all 0 within %0d cycles",
                     name, exp_wr.size(), exp_tx.size(), rxq.size(), budget);
        end
        n_checks++;
        if ({boot_done, boot_err, core_hold} !== {done, err, ~done}) begin
            n_fail++;
            $display("FAIL %s_status: done/err/hold=%b%b%b, required %b%b%b",
                     name, boot_done, boot_err, core_hold, done, err, ~done);
        end
    endtask

    task automatic rearm();
        boot_req = 1'b1;
        tick();
        boot_req = 1'b0;
        n_checks++;
        if (core_hold !== 1'b1 || boot_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm: hold=%b done=%b, required hold=1 done=0", core_hold, boot_done);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({core_hold, boot_done, boot_err, rx_rd, tx_wr, imem_we} !== 6'b100000 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: hold/done/err/rd/wr/we=%b%b%b%b%b%b addr=%h wdata=%h txd=%h, required 100000 and zeros",
                     name, core_hold, boot_done, boot_err, rx_rd, tx_wr, imem_we, imem_addr, imem_wdata, tx_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        send_frame(8'h00);
        wait_status("good_frame", 1'b1, 1'b0, 200);
    endtask

    task automatic test_bad_csum();
        rearm();
        send_frame(8'h01);
        wait_status("bad_csum", 1'b0, 1'b1, 200);
    endtask

    task automatic test_junk();
        rearm();
        rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'h5A);
        send_frame(8'h00);
        wait_status("junk", 1'b1, 1'b0, 200);
    endtask

    task automatic test_bad_count();
        logic [15:0] counts[2];
        counts[0] = 16'd257;
        counts[1] = 16'd0;
        for (int i = 0; i < 2; i++) begin
            rearm();
            rxq.push_back(8'hA5); rxq.push_back(counts[i][7:0]); rxq.push_back(counts[i][15:8]);
            exp_tx.push_back(8'h15);
            wait_status("bad_count", 1'b0, 1'b1, 50);
        end
    endtask

    task automatic test_timeout();
        rearm();
        rxq.push_back(8'hA5); rxq.push_back(8'h02); rxq.push_back(8'h00);
        rxq.push_back(8'h13); rxq.push_back(8'h00); rxq.push_back(8'h00);
        exp_tx.push_back(8'h15);
        repeat (2 * TMO + 8) tick();
        n_checks++;
        if (boot_err !== 1'b1 || boot_done !== 1'b0 || exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_nak: err=%b done=%b tx_left=%0d, required err=1 done=0 tx_left=0",
                     boot_err, boot_done, exp_tx.size());
        end
        rxq.push_back(8'hA5);
        send_frame(8'h00);
        wait_status("after_timeout", 1'b1, 1'b0, 200);
    endtask

    task automatic test_tx_full_then_reset();
        int n;
        rearm();
        tx_full = 1'b1;
        send_frame(8'h00);
        n = 0;
        while (n < 100 && (rxq.size() != 0 || exp_wr.size() != 0)) begin
            tick();
            n++;
        end
        repeat (50) tick();
        n_checks++;
        if (exp_tx.size() != 1 || boot_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_full_hold: tx_left=%0d done=%b, required tx_left=1 done=0",
                     exp_tx.size(), boot_done);
        end
        tx_full = 1'b0;
        wait_status("tx_release", 1'b1, 1'b0, 20);
        rearm();
        rxq.push_back(8'hA5); rxq.push_back(8'h02); rxq.push_back(8'h00); rxq.push_back(8'h13);
        n = 0;
        while (n < 20 && rxq.size() != 0) begin
            tick();
            n++;
        end
        rxq.push_back(8'h00);
        refresh();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_mid_data");
        rxq.delete();
        refresh();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset_release");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_junk();
        test_bad_count();
        test_timeout();
        test_tx_full_then_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
